// File: rtl/result_store_writer.sv
// Double-buffered drain of MAC result vectors into a narrow, back-pressured memory write port.
// Optional build macro STORE_RELU_EN zeroes negative words on the write-data path.
module result_store_writer #(
    parameter int MAC_NUM  = 112,
    parameter int WR_LANES = 8,
    parameter int ADDR_W   = 12,
    parameter int VCNT_W   = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [VCNT_W-1:0]       num_vec,
    input  logic                    store_vld,
    input  logic [MAC_NUM*16-1:0]   store_data_16,
    output logic                    store_rdy,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [WR_LANES*16-1:0]  mem_wdata,
    input  logic                    mem_rdy,
    output logic                    busy,
    output logic                    done
);

    localparam int BEATS  = (MAC_NUM + WR_LANES - 1) / WR_LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam int VEC_W  = MAC_NUM * 16;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [VCNT_W-1:0]   drain_cnt_reg;
    logic [VCNT_W-1:0]   accept_cnt_reg;
    logic [1:0]          full_reg;
    logic                wp_reg;
    logic                rp_reg;
    logic [BEAT_W-1:0]   beat_reg;
    logic [VEC_W-1:0]    vbuf [2];

    logic                run;
    logic                accept;
    logic                beat_fire;
    logic                last_beat;
    logic [VEC_W-1:0]    sel_vec;
    logic [15:0]         col_words [WR_LANES][BEATS];

    assign run       = (state_reg == S_RUN);
    // Readiness also stops once every vector of the phase has been taken in.
    assign store_rdy = run && (accept_cnt_reg != '0) && !(&full_reg);
    assign accept    = store_vld && store_rdy;
    assign mem_we    = run && full_reg[rp_reg];
    assign beat_fire = mem_we && mem_rdy;
    assign last_beat = beat_fire && (beat_reg == LAST_BEAT);
    assign mem_addr  = addr_reg;
    assign busy      = run;
    assign done      = (state_reg == S_DONE);
    assign sel_vec   = vbuf[rp_reg];

    // Lanes past MAC_NUM in the final beat are tied to zero.
    genvar gi, gk;
    generate
        for (gk = 0; gk < WR_LANES; gk++) begin : g_lane
            for (gi = 0; gi < BEATS; gi++) begin : g_beat
                if (gi * WR_LANES + gk < MAC_NUM) begin : g_real
                    assign col_words[gk][gi] = sel_vec[(gi*WR_LANES+gk)*16 +: 16];
                end else begin : g_pad
                    assign col_words[gk][gi] = 16'h0000;
                end
            end

            logic [15:0] raw;
            assign raw = col_words[gk][beat_reg];
`ifdef STORE_RELU_EN
            assign mem_wdata[gk*16 +: 16] = (mem_we && !raw[15]) ? raw : 16'h0000;
`else
            assign mem_wdata[gk*16 +: 16] = mem_we ? raw : 16'h0000;
`endif
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            addr_reg       <= '0;
            drain_cnt_reg  <= '0;
            accept_cnt_reg <= '0;
            full_reg       <= '0;
            wp_reg         <= 1'b0;
            rp_reg         <= 1'b0;
            beat_reg       <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        addr_reg       <= base_addr;
                        drain_cnt_reg  <= num_vec;
                        accept_cnt_reg <= num_vec;
                        full_reg       <= '0;
                        wp_reg         <= 1'b0;
                        rp_reg         <= 1'b0;
                        beat_reg       <= '0;
                        state_reg      <= (num_vec == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    // Accept and free always target different entries, so both may happen at once.
                    if (accept) begin
                        full_reg[wp_reg] <= 1'b1;
                        wp_reg           <= ~wp_reg;
                        accept_cnt_reg   <= accept_cnt_reg - 1'b1;
                    end
                    if (beat_fire) begin
                        addr_reg <= addr_reg + 1'b1;
                        if (last_beat) begin
                            beat_reg         <= '0;
                            full_reg[rp_reg] <= 1'b0;
                            rp_reg           <= ~rp_reg;
                            drain_cnt_reg    <= drain_cnt_reg - 1'b1;
                            if (drain_cnt_reg == VCNT_W'(1)) begin
                                state_reg <= S_DONE;
                            end
                        end else begin
                            beat_reg <= beat_reg + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // Vector storage carries no reset; the full flags alone decide what is valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            vbuf[wp_reg] <= store_data_16;
        end
    end

endmodule

// File: tb/tb_result_store_writer.sv
// Directed bench for result_store_writer: default 112-lane instance plus a 20-lane padding instance.
module tb_result_store_writer;

    localparam int MAC_NUM  = 112;
    localparam int WR_LANES = 8;
    localparam int BEATS    = 14;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic [11:0]             base_addr;
    logic [9:0]              num_vec;
    logic                    store_vld;
    logic [MAC_NUM*16-1:0]   store_data_16;
    logic                    store_rdy;
    logic                    mem_we;
    logic [11:0]             mem_addr;
    logic [127:0]            mem_wdata;
    logic                    mem_rdy;
    logic                    busy;
    logic                    done;

    logic                    p_start;
    logic                    p_vld;
    logic [319:0]            p_data;
    logic                    p_store_rdy;
    logic                    p_mem_we;
    logic [11:0]             p_mem_addr;
    logic [127:0]            p_mem_wdata;
    logic                    p_mem_rdy;
    logic                    p_busy;
    logic                    p_done;

    int n_checks = 0;
    int n_errors = 0;
    logic [MAC_NUM*16-1:0] vecs [5];
    logic rdy_after [3];

    always #5 clk = ~clk;

    result_store_writer #(.MAC_NUM(112), .WR_LANES(8), .ADDR_W(12), .VCNT_W(10)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_vec(num_vec),
        .store_vld(store_vld), .store_data_16(store_data_16), .store_rdy(store_rdy),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdy(mem_rdy),
        .busy(busy), .done(done)
    );

    result_store_writer #(.MAC_NUM(20), .WR_LANES(8), .ADDR_W(12), .VCNT_W(10)) dutp (
        .clk(clk), .rst(rst), .start(p_start), .base_addr(base_addr), .num_vec(num_vec),
        .store_vld(p_vld), .store_data_16(p_data), .store_rdy(p_store_rdy),
        .mem_we(p_mem_we), .mem_addr(p_mem_addr), .mem_wdata(p_mem_wdata), .mem_rdy(p_mem_rdy),
        .busy(p_busy), .done(p_done)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] exp_beat(input int vi, input int b);
        logic [127:0] r;
        logic [15:0]  w;
        int           lane;
        r = '0;
        for (int k = 0; k < WR_LANES; k++) begin
            lane = b * WR_LANES + k;
            w = (lane < MAC_NUM) ? vecs[vi][lane*16 +: 16] : 16'h0000;
`ifdef STORE_RELU_EN
            if (w[15]) w = 16'h0000;
`endif
            r[k*16 +: 16] = w;
        end
        return r;
    endfunction

    task automatic do_start(input logic [11:0] b, input logic [9:0] n);
        base_addr = b;
        num_vec   = n;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_rise", busy, 1'b1);
    endtask

    task automatic feed(input int n, input int vfirst);
        for (int v = 0; v < n; v++) begin
            int w;
            w = 0;
            store_data_16 = vecs[vfirst + v];
            store_vld     = 1'b1;
            while (store_rdy !== 1'b1 && w < 300) begin
                @(posedge clk); #1;
                w++;
            end
            check("feed_wait", (w < 300), 1'b1);
            @(posedge clk); #1;
            rdy_after[v] = store_rdy;
            check("latency_we", mem_we, 1'b1);
            $display("accept vec %0d", vfirst + v);
        end
        store_vld = 1'b0;
    endtask

    // mode 0: mem_rdy always high; mode 1: mem_rdy pattern 1,0,0,1 repeating.
    task automatic drain(input int nbeats, input logic [11:0] base, input int vfirst, input int mode);
        int got;
        int cyc;
        logic [11:0] ea;
        got = 0;
        cyc = 0;
        while (got < nbeats && cyc < 400) begin
            mem_rdy = (mode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
            if (mem_we) begin
                ea = base + 12'(got);
                check("addr", mem_addr, ea);
                check("data", mem_wdata, exp_beat(vfirst + got / BEATS, got % BEATS));
                if (mem_rdy) begin
                    $display("beat %0d addr=%h data=%h", got, mem_addr, mem_wdata);
                    got++;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        mem_rdy = 1'b0;
        check("drain_beats", got, nbeats);
    endtask

    task automatic check_done();
        check("done_high", done, 1'b1);
        check("busy_fall", busy, 1'b0);
        check("we_after", mem_we, 1'b0);
        @(posedge clk); #1;
        check("done_pulse", done, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; num_vec = '0;
        store_vld = 1'b0; store_data_16 = '0; mem_rdy = 1'b0;
        p_start = 1'b0; p_vld = 1'b0; p_data = '0; p_mem_rdy = 1'b0;
        for (int v = 0; v < 4; v++)
            for (int j = 0; j < MAC_NUM; j++)
                vecs[v][j*16 +: 16] = 16'(v * 256 + j);
        vecs[4] = vecs[0];
        vecs[4][15:0] = 16'h8123;
        for (int j = 0; j < 20; j++) p_data[j*16 +: 16] = 16'(16'h0100 + j);

        repeat (2) @(posedge clk);
        #1;
        check("rst_store_rdy", store_rdy, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 12'h000);
        check("rst_mem_wdata", mem_wdata, 128'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic drain: one vector, lane j = j, from 0x100.
        do_start(12'h100, 10'd1);
        fork
            feed(1, 0);
            drain(14, 12'h100, 0, 0);
        join
        check_done();

        // Backpressure: two vectors under a 1,0,0,1 ready pattern.
        do_start(12'h040, 10'd2);
        fork
            feed(2, 1);
            drain(28, 12'h040, 1, 1);
        join
        check_done();

        // Back-to-back: three vectors with store_vld held.
        do_start(12'h080, 10'd3);
        fork
            feed(3, 0);
            drain(42, 12'h080, 0, 0);
        join
        check("rdy_after_1st", rdy_after[0], 1'b1);
        check("rdy_both_full", rdy_after[1], 1'b0);
        check("rdy_after_3rd", rdy_after[2], 1'b0);
        check_done();

        // Address wrap from 0xFFA.
        do_start(12'hFFA, 10'd1);
        fork
            feed(1, 3);
            drain(14, 12'hFFA, 3, 0);
        join
        check_done();

        // Zero-vector phase.
        base_addr = 12'h123;
        num_vec   = 10'd0;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("zero_done", done, 1'b1);
        check("zero_busy", busy, 1'b0);
        check("zero_we", mem_we, 1'b0);
        check("zero_rdy", store_rdy, 1'b0);
        @(posedge clk); #1;
        check("zero_done_pulse", done, 1'b0);

        // Padding instance: 20 lanes give three beats, last one half zero.
        base_addr = 12'h020;
        num_vec   = 10'd1;
        p_start   = 1'b1;
        @(posedge clk); #1;
        p_start = 1'b0;
        p_vld   = 1'b1;
        check("pad_rdy", p_store_rdy, 1'b1);
        @(posedge clk); #1;
        p_vld     = 1'b0;
        p_mem_rdy = 1'b1;
        check("pad_b0_addr", p_mem_addr, 12'h020);
        check("pad_b0_data", p_mem_wdata,
              {16'h0107, 16'h0106, 16'h0105, 16'h0104, 16'h0103, 16'h0102, 16'h0101, 16'h0100});
        $display("pad beat 0 addr=%h data=%h", p_mem_addr, p_mem_wdata);
        @(posedge clk); #1;
        check("pad_b1_addr", p_mem_addr, 12'h021);
        check("pad_b1_data", p_mem_wdata,
              {16'h010F, 16'h010E, 16'h010D, 16'h010C, 16'h010B, 16'h010A, 16'h0109, 16'h0108});
        $display("pad beat 1 addr=%h data=%h", p_mem_addr, p_mem_wdata);
        @(posedge clk); #1;
        check("pad_b2_addr", p_mem_addr, 12'h022);
        check("pad_b2_data", p_mem_wdata,
              {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0113, 16'h0112, 16'h0111, 16'h0110});
        $display("pad beat 2 addr=%h data=%h", p_mem_addr, p_mem_wdata);
        @(posedge clk); #1;
        p_mem_rdy = 1'b0;
        check("pad_done", p_done, 1'b1);
        check("pad_we_after", p_mem_we, 1'b0);

        // Negative word handling, then reset in the middle of a phase.
        mem_rdy = 1'b1;
        do_start(12'h200, 10'd1);
        feed(1, 4);
`ifdef STORE_RELU_EN
        check("relu_word0", mem_wdata[15:0], 16'h0000);
`else
        check("relu_word0", mem_wdata[15:0], 16'h8123);
`endif
        check("relu_word1", mem_wdata[31:16], 16'h0001);
        repeat (5) @(posedge clk);
        #1;
        check("beat5_addr", mem_addr, 12'h205);
        rst = 1'b1;
        #1;
        check("mid_rst_we", mem_we, 1'b0);
        check("mid_rst_addr", mem_addr, 12'h000);
        check("mid_rst_wdata", mem_wdata, 128'h0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_rdy", store_rdy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        mem_rdy = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        do_start(12'h300, 10'd1);
        fork
            feed(1, 1);
            drain(14, 12'h300, 1, 0);
        join
        check_done();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
